// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- machine-mode trap / interrupt sequencer
//
// Accepts one event at a time (ecall, mret, external IRQ, timer IRQ) while idle
// and the pipe is not stalled. It then walks the CSR write port through the
// mepc / mcause / mstatus updates, one write per cycle, and ends the sequence
// with a one-cycle redirect pulse that carries the new PC.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   ext_irq_i      external interrupt request (level)
//   timer_irq_i    timer interrupt request (level)
//   ecall_i        ecall retiring this cycle (1-cycle pulse)
//   mret_i         mret retiring this cycle (1-cycle pulse)
//   stall_i        pipeline stalled; no new event is accepted
//   pc_i           PC saved to mepc on trap entry
//   csr_mtvec_i    current mtvec (direct mode only)
//   csr_mepc_i     current mepc
//   csr_mstatus_i  current mstatus
//   csr_mie_i      current mie
//   csr_we_o       CSR write strobe
//   csr_waddr_o    CSR write address
//   csr_wdata_o    CSR write data
//   int_en_o       redirect / flush pulse (1 cycle)
//   isr_pc_o       redirect target, valid with int_en_o, otherwise 0
//   busy_o         sequence in progress; the pipe keeps its stall while high
//
// DATA_WIDTH must be at least ADDR_WIDTH, because the redirect target is taken
// from the low ADDR_WIDTH bits of mtvec / mepc.
// -----------------------------------------------------------------------------
module int_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ext_irq_i,
  input  logic                  timer_irq_i,
  input  logic                  ecall_i,
  input  logic                  mret_i,
  input  logic                  stall_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
  input  logic [DATA_WIDTH-1:0] csr_mepc_i,
  input  logic [DATA_WIDTH-1:0] csr_mstatus_i,
  input  logic [DATA_WIDTH-1:0] csr_mie_i,
  output logic                  csr_we_o,
  output logic [11:0]           csr_waddr_o,
  output logic [DATA_WIDTH-1:0] csr_wdata_o,
  output logic                  int_en_o,
  output logic [ADDR_WIDTH-1:0] isr_pc_o,
  output logic                  busy_o
);

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mstatus / mie bit positions
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;
  localparam int MEIE_BIT = 11;
  localparam int MTIE_BIT = 7;

  // mcause values; the interrupt flag sits in the MSB
  localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL = DATA_WIDTH'(11);
  localparam logic [DATA_WIDTH-1:0] CAUSE_EXT   = {1'b1, (DATA_WIDTH-1)'(11)};
  localparam logic [DATA_WIDTH-1:0] CAUSE_TIMER = {1'b1, (DATA_WIDTH-1)'(7)};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_EPC,
    S_WR_CAUSE,
    S_WR_STAT,
    S_MRET_STAT,
    S_JUMP
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   cause_q, cause_d;
  logic                    mret_q, mret_d;   // JUMP target select: 1 = mepc, 0 = mtvec

  logic                    ext_pend;
  logic                    timer_pend;
  logic [DATA_WIDTH-1:0]   mstatus_trap;
  logic [DATA_WIDTH-1:0]   mstatus_mret;

  // IRQs are enabled both globally (MIE) and individually (mie).
  // ecall and mret are never gated.
  assign ext_pend   = ext_irq_i   && csr_mstatus_i[MIE_BIT] && csr_mie_i[MEIE_BIT];
  assign timer_pend = timer_irq_i && csr_mstatus_i[MIE_BIT] && csr_mie_i[MTIE_BIT];

  // mstatus images, computed from the live CSR value in the state that writes them
  always_comb begin
    mstatus_trap                 = csr_mstatus_i;
    mstatus_trap[MPIE_BIT]       = csr_mstatus_i[MIE_BIT];
    mstatus_trap[MIE_BIT]        = 1'b0;
    mstatus_trap[MPP_HI:MPP_LO]  = 2'b11;

    mstatus_mret                 = csr_mstatus_i;
    mstatus_mret[MIE_BIT]        = csr_mstatus_i[MPIE_BIT];
    mstatus_mret[MPIE_BIT]       = 1'b1;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    mret_d  = mret_q;

    case (state_q)
      S_IDLE: begin
        if (!stall_i) begin
          if (ecall_i) begin
            state_d = S_WR_EPC;
            pc_d    = pc_i;
            cause_d = CAUSE_ECALL;
            mret_d  = 1'b0;
          end else if (mret_i) begin
            state_d = S_MRET_STAT;
            mret_d  = 1'b1;
          end else if (ext_pend) begin
            state_d = S_WR_EPC;
            pc_d    = pc_i;
            cause_d = CAUSE_EXT;
            mret_d  = 1'b0;
          end else if (timer_pend) begin
            state_d = S_WR_EPC;
            pc_d    = pc_i;
            cause_d = CAUSE_TIMER;
            mret_d  = 1'b0;
          end
        end
      end
      S_WR_EPC:    state_d = S_WR_CAUSE;
      S_WR_CAUSE:  state_d = S_WR_STAT;
      S_WR_STAT:   state_d = S_JUMP;
      S_MRET_STAT: state_d = S_JUMP;
      S_JUMP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State register. A reset in any state aborts the sequence: the next cycle is
  // IDLE, and since every output is decoded from state, no further CSR write goes out.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, whatever the statement order.
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  // Output decode: the state selects the outputs; CSR data is sampled live.
  // int_en_o only asserts in JUMP, which never writes a CSR.
  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    int_en_o    = 1'b0;
    isr_pc_o    = '0;
    busy_o      = (state_q != S_IDLE);

    case (state_q)
      S_WR_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = DATA_WIDTH'(pc_q);
      end
      S_WR_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      S_WR_STAT: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstatus_trap;
      end
      S_MRET_STAT: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstatus_mret;
      end
      S_JUMP: begin
        int_en_o = 1'b1;
        if (mret_q) isr_pc_o = csr_mepc_i[ADDR_WIDTH-1:0];
        else        isr_pc_o = {csr_mtvec_i[ADDR_WIDTH-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  // Only a few mie bits and no mtvec mode bits are consumed.
  logic unused_ok;
  assign unused_ok = ^{csr_mie_i, csr_mtvec_i, csr_mepc_i};

endmodule
